// File: rtl/mux6b2_arbiter.sv
// Two-requester round-robin arbiter feeding a one-entry output register.
// Requesters A and B share a single 2:1 select path. A grant lasts until the
// holder drops valid or has made MAX_BURST consecutive transfers while the
// other requester is waiting.
module mux6b2_arbiter #(
    parameter int unsigned WIDTH     = 6,
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned FIRST_PRI = 0
) (
    input  logic             CLK,
    input  logic             Reset_n,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_valid,
    output logic             b_ready,
    output logic [WIDTH-1:0] r_data,
    output logic             r_valid,
    input  logic             r_ready,
    output logic             sel,
    output logic             busy
);

    typedef enum logic [1:0] {
        StIdle,
        StServeA,
        StServeB
    } state_t;

    // Count value of the last transfer allowed in one burst.
    localparam logic [3:0] LastCnt = 4'(MAX_BURST - 1);

    state_t     state;
    logic [3:0] burst_cnt;
    logic       pri;        // 0 = A wins the next IDLE tie, 1 = B
    logic       can_load;

    // Slot is free if empty or being drained this very cycle.
    always_comb begin
        can_load = !r_valid || r_ready;
        a_ready  = (state == StServeA) && a_valid && can_load;
        b_ready  = (state == StServeB) && b_valid && can_load;
        busy     = (state != StIdle);
    end

    // Arbitration FSM and the output register, all registered state.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= StIdle;
            r_data    <= '0;
            r_valid   <= 1'b0;
            sel       <= 1'b0;
            burst_cnt <= 4'd0;
            pri       <= 1'(FIRST_PRI);
        end else begin
            // A load wins over a pop, so a same-cycle pop+load keeps r_valid high.
            if (a_ready) begin
                r_data  <= a_data;
                r_valid <= 1'b1;
            end else if (b_ready) begin
                r_data  <= b_data;
                r_valid <= 1'b1;
            end else if (r_ready) begin
                r_valid <= 1'b0;
            end

            unique case (state)
                StIdle: begin
                    if (a_valid && (!b_valid || !pri)) begin
                        state     <= StServeA;
                        sel       <= 1'b0;
                        burst_cnt <= 4'd0;
                    end else if (b_valid) begin
                        state     <= StServeB;
                        sel       <= 1'b1;
                        burst_cnt <= 4'd0;
                    end
                end
                StServeA: begin
                    if (!a_valid) begin
                        pri       <= 1'b1;
                        burst_cnt <= 4'd0;
                        if (b_valid) begin
                            state <= StServeB;
                            sel   <= 1'b1;
                        end else begin
                            state <= StIdle;
                        end
                    end else if (a_ready) begin
                        if (burst_cnt == LastCnt) begin
                            // Burst used up: hand over only if B is waiting.
                            burst_cnt <= 4'd0;
                            if (b_valid) begin
                                state <= StServeB;
                                sel   <= 1'b1;
                                pri   <= 1'b0;
                            end
                        end else begin
                            burst_cnt <= burst_cnt + 4'd1;
                        end
                    end
                end
                StServeB: begin
                    if (!b_valid) begin
                        pri       <= 1'b0;
                        burst_cnt <= 4'd0;
                        if (a_valid) begin
                            state <= StServeA;
                            sel   <= 1'b0;
                        end else begin
                            state <= StIdle;
                        end
                    end else if (b_ready) begin
                        if (burst_cnt == LastCnt) begin
                            burst_cnt <= 4'd0;
                            if (a_valid) begin
                                state <= StServeA;
                                sel   <= 1'b0;
                                pri   <= 1'b1;
                            end
                        end else begin
                            burst_cnt <= burst_cnt + 4'd1;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
